// File: rtl/fpmul_ctrl.sv
// IEEE-754 single-precision multiply controller driving an external booth mantissa multiplier.
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise the product is truncated.
module fpmul_ctrl (
  input  logic        CLK,
  input  logic        RSTK,
  input  logic        Mul_valid,
  input  logic [31:0] Mul_opa,
  input  logic [31:0] Mul_opb,
  output logic        Mul_ack,
  output logic [31:0] Mul_result,
  output logic [1:0]  Mul_Exc,
  output logic        Booth_req,
  output logic [23:0] Booth_m1,
  output logic [23:0] Booth_m2,
  input  logic        Booth_ack,
  input  logic [47:0] Booth_res
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StRound, StDone} state_e;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  expsum_q, expsum_d;
  logic [23:0]        m1_q, m1_d, m2_q, m2_d;
  logic [47:0]        prod_q, prod_d;
  logic [31:0]        result_q, result_d;
  logic [1:0]         exc_q, exc_d;

  // Operand classification, evaluated on the raw inputs while Idle
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        op_sign;
  logic [9:0]  op_expsum;

  assign ea        = Mul_opa[30:23];
  assign eb        = Mul_opb[30:23];
  assign fa        = Mul_opa[22:0];
  assign fb        = Mul_opb[22:0];
  assign a_nan     = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan     = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf     = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf     = (eb == 8'hFF) && (fb == 23'd0);
  // Denormals are flushed, so any zero exponent counts as zero
  assign a_zero    = (ea == 8'h00);
  assign b_zero    = (eb == 8'h00);
  assign op_sign   = Mul_opa[31] ^ Mul_opb[31];
  assign op_expsum = {2'b00, ea} + {2'b00, eb} - 10'd127;

  // Normalisation and rounding of the captured product
  logic              norm_hi;
  logic [22:0]       mant_n, mant_r;
  logic              carry;
  logic signed [9:0] exp_n, exp_r;

  assign norm_hi = prod_q[47];
  assign mant_n  = norm_hi ? prod_q[46:24] : prod_q[45:23];
  assign exp_n   = expsum_q + (norm_hi ? 10'sd1 : 10'sd0);

`ifdef FPMUL_RNE_EN
  logic guard, sticky, round_inc;
  assign guard     = norm_hi ? prod_q[23] : prod_q[22];
  assign sticky    = norm_hi ? |prod_q[22:0] : |prod_q[21:0];
  assign round_inc = guard & (sticky | mant_n[0]);
  // All-ones mantissa rolls over to zero with the carry bumping the exponent
  assign {carry, mant_r} = {1'b0, mant_n} + {23'd0, round_inc};
`else
  logic unused_prod_lsbs;
  assign unused_prod_lsbs = ^prod_q[22:0];
  assign carry  = 1'b0;
  assign mant_r = mant_n;
`endif

  assign exp_r = exp_n + $signed({9'd0, carry});

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    expsum_d = expsum_q;
    m1_d     = m1_q;
    m2_d     = m2_q;
    prod_d   = prod_q;
    result_d = result_q;
    exc_d    = exc_q;
    unique case (state_q)
      StIdle: begin
        if (Mul_valid) begin
          sign_d   = op_sign;
          expsum_d = $signed(op_expsum);
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result_d = 32'h7FC0_0000;
            exc_d    = 2'b11;
            state_d  = StDone;
          end else if (a_inf || b_inf) begin
            result_d = {op_sign, 8'hFF, 23'd0};
            exc_d    = 2'b00;
            state_d  = StDone;
          end else if (a_zero || b_zero) begin
            result_d = {op_sign, 31'd0};
            exc_d    = 2'b00;
            state_d  = StDone;
          end else begin
            m1_d    = {1'b1, fa};
            m2_d    = {1'b1, fb};
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (Booth_ack) begin
          prod_d  = Booth_res;
          state_d = StRound;
        end
      end
      StRound: begin
        if (exp_r >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          exc_d    = 2'b01;
        end else if (exp_r <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          exc_d    = 2'b10;
        end else begin
          result_d = {sign_q, exp_r[7:0], mant_r};
          exc_d    = 2'b00;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTK) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      expsum_q <= 10'sd0;
      m1_q     <= 24'd0;
      m2_q     <= 24'd0;
      prod_q   <= 48'd0;
      result_q <= 32'd0;
      exc_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      expsum_q <= expsum_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign Booth_req  = (state_q == StIssue);
  assign Mul_ack    = (state_q == StDone);
  assign Booth_m1   = m1_q;
  assign Booth_m2   = m2_q;
  assign Mul_result = result_q;
  assign Mul_Exc    = exc_q;

endmodule

// File: tb/tb_fpmul_ctrl.sv
// Self-checking bench for fpmul_ctrl: directed and random operands against an arithmetic model,
// with the booth multiplier emulated inline at random latency.
module tb_fpmul_ctrl;

  logic        CLK = 1'b0;
  logic        RSTK;
  logic        Mul_valid;
  logic [31:0] Mul_opa, Mul_opb;
  logic        Mul_ack;
  logic [31:0] Mul_result;
  logic [1:0]  Mul_Exc;
  logic        Booth_req;
  logic [23:0] Booth_m1, Booth_m2;
  logic        Booth_ack;
  logic [47:0] Booth_res;

  int n_checks = 0;
  int n_errors = 0;

  fpmul_ctrl dut (
    .CLK        (CLK),
    .RSTK       (RSTK),
    .Mul_valid  (Mul_valid),
    .Mul_opa    (Mul_opa),
    .Mul_opb    (Mul_opb),
    .Mul_ack    (Mul_ack),
    .Mul_result (Mul_result),
    .Mul_Exc    (Mul_Exc),
    .Booth_req  (Booth_req),
    .Booth_m1   (Booth_m1),
    .Booth_m2   (Booth_m2),
    .Booth_ack  (Booth_ack),
    .Booth_res  (Booth_res)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {exc, result} computed from the IEEE rules with plain integer arithmetic
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int                ea, eb, e, sh;
    logic              s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned   p, mant, rem, half;
    logic [31:0]       res;
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    s      = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {2'b11, 32'h7FC00000};
    if (a_inf || b_inf) return {2'b00, s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {2'b00, s, 31'd0};
    p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    e    = ea + eb - 127 + (sh - 23);
    mant = p >> sh;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
`ifdef FPMUL_RNE_EN
    if (rem > half || (rem == half && mant[0])) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e    = e + 1;
    end
`else
    if (rem > half) mant = mant;
`endif
    if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b10, s, 31'd0};
    res = {s, e[7:0], mant[22:0]};
    return {2'b00, res};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          r;
    r = $urandom_range(0, 9);
    if (r == 0) e = 8'd0;
    else if (r == 1) e = 8'hFF;
    else if (r <= 5) e = 8'($urandom_range(100, 154));
    else e = 8'($urandom_range(1, 254));
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    logic [33:0] exp_v;
    logic        special;
    logic [23:0] ma, mb;
    int          lat;
    exp_v   = ref_mul(a, b);
    special = (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) ||
              (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
    ma      = {1'b1, a[22:0]};
    mb      = {1'b1, b[22:0]};
    @(negedge CLK);
    Mul_valid = 1'b1;
    Mul_opa   = a;
    Mul_opb   = b;
    // A stray booth ack while Idle must be ignored
    Booth_ack = 1'($urandom_range(0, 1));
    Booth_res = {16'($urandom), 32'($urandom)};
    @(negedge CLK);
    Mul_valid = 1'b0;
    Booth_ack = 1'b0;
    Mul_opa   = $urandom;
    Mul_opb   = $urandom;
    if (special) begin
      check("special_ack", 48'(Mul_ack), 48'd1);
      check("special_noreq", 48'(Booth_req), 48'd0);
      check("special_result", 48'(Mul_result), 48'(exp_v[31:0]));
      check("special_exc", 48'(Mul_Exc), 48'(exp_v[33:32]));
      @(negedge CLK);
      check("special_ack_pulse", 48'(Mul_ack), 48'd0);
    end else begin
      check("issue_req", 48'(Booth_req), 48'd1);
      check("issue_noack", 48'(Mul_ack), 48'd0);
      check("issue_m1", 48'(Booth_m1), 48'(ma));
      check("issue_m2", 48'(Booth_m2), 48'(mb));
      lat = $urandom_range(1, 4);
      repeat (lat) begin
        @(negedge CLK);
        check("wait_req_low", 48'(Booth_req), 48'd0);
        check("wait_noack", 48'(Mul_ack), 48'd0);
      end
      check("wait_m1_stable", 48'(Booth_m1), 48'(ma));
      check("wait_m2_stable", 48'(Booth_m2), 48'(mb));
      Booth_ack = 1'b1;
      Booth_res = {24'd0, ma} * {24'd0, mb};
      @(negedge CLK);
      // Garbage ack during Round must not be recaptured
      Booth_ack = 1'($urandom_range(0, 1));
      Booth_res = {16'($urandom), 32'($urandom)};
      check("round_noack", 48'(Mul_ack), 48'd0);
      check("round_noreq", 48'(Booth_req), 48'd0);
      @(negedge CLK);
      Booth_ack = 1'b0;
      check("done_ack", 48'(Mul_ack), 48'd1);
      check("done_result", 48'(Mul_result), 48'(exp_v[31:0]));
      check("done_exc", 48'(Mul_Exc), 48'(exp_v[33:32]));
      @(negedge CLK);
      check("done_ack_pulse", 48'(Mul_ack), 48'd0);
      check("done_result_hold", 48'(Mul_result), 48'(exp_v[31:0]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, 48'(Mul_ack), 48'd0);
    check({tag, "_result"}, 48'(Mul_result), 48'd0);
    check({tag, "_exc"}, 48'(Mul_Exc), 48'd0);
    check({tag, "_req"}, 48'(Booth_req), 48'd0);
    check({tag, "_m1"}, 48'(Booth_m1), 48'd0);
    check({tag, "_m2"}, 48'(Booth_m2), 48'd0);
  endtask

  initial begin
    RSTK      = 1'b0;
    Mul_valid = 1'b0;
    Mul_opa   = 32'd0;
    Mul_opb   = 32'd0;
    Booth_ack = 1'b0;
    Booth_res = 48'd0;
    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    RSTK = 1'b1;

    do_op(32'h3FC00000, 32'h40000000);
    do_op(32'h3FC00001, 32'h3FC00001);
    do_op(32'h7F000000, 32'h7F000000);
    do_op(32'h00800000, 32'h00800000);
    do_op(32'h7F800000, 32'h00000000);
    do_op(32'hFF800000, 32'h40000000);
    do_op(32'h7FC00001, 32'h3F800000);
    do_op(32'hBF800000, 32'h007FFFFF);
    do_op(32'h3FFFFFFF, 32'h3FFFFFFF);

    // Abort during Wait: reset for one cycle, then a late booth result must be ignored
    @(negedge CLK);
    Mul_valid = 1'b1;
    Mul_opa   = 32'h3FC00000;
    Mul_opb   = 32'h40000000;
    @(negedge CLK);
    Mul_valid = 1'b0;
    check("abort_issue_req", 48'(Booth_req), 48'd1);
    @(negedge CLK);
    RSTK = 1'b0;
    @(negedge CLK);
    RSTK = 1'b1;
    check_reset_values("abort");
    Booth_ack = 1'b1;
    Booth_res = 48'h600000000000;
    @(negedge CLK);
    Booth_ack = 1'b0;
    repeat (3) begin
      check("abort_no_ack", 48'(Mul_ack), 48'd0);
      check("abort_no_req", 48'(Booth_req), 48'd0);
      @(negedge CLK);
    end
    do_op(32'h3F800000, 32'h3F800000);

    for (int i = 0; i < 80; i++) begin
      do_op(rand_op(), rand_op());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
